queue_issue_arbiter: RTL and testbench
======================================

# queue_issue_arbiter

Round-robin issue arbiter that shares the two write slots of the dual-entry pipeline queue among NUM_REQ producer stages. Each cycle it grants up to two requesters, packs their data into queue slot 1 then slot 2, and registers `valid1/valid2/data1/data2` toward the queue. It honours the queue's two-bit `stall_out` back-pressure. It also sequences queue flushes: one FLUSH pulse, followed by a programmable quiesce window with no grants.

## Interface
- `DATA_WIDTH`, 16, width of each request and queue data word
- `NUM_REQ`, 4, number of requesters (2..8)
- `QUIESCE_CYCLES`, 2, no-grant cycles after a FLUSH pulse (1..15)
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `req` in NUM_REQ: per-requester request, level
- `req_data` in NUM_REQ*DATA_WIDTH: requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `gnt` out NUM_REQ: combinational; gnt[i]=1 means req_data[i] is accepted this cycle
- `stall_in` in 2: queue back-pressure, taken from the queue's `stall_out`
- `flush_req` in 1: single-cycle request to flush the queue
- `q_valid1`, `q_valid2` out 1: registered slot valids to the queue
- `q_data1`, `q_data2` out DATA_WIDTH: registered slot data to the queue
- `q_flush` out 1: registered FLUSH to the queue
- `busy` out 1: high while the FSM is in FLUSH or QUIESCE

## Operation
- Capacity `cap` from `stall_in`:
  - 00 gives 2.
  - 10 gives 1.
  - 11 or 01 gives 0. 01 is illegal and is treated as full.
- Arbitration in IDLE:
  - First grant `g0` is the lowest index, cyclically at or after `rr_ptr`, with req=1.
  - Second grant `g1` is the next requesting index cyclically after `g0`.
  - Grants issued = min(cap, number of requests).
  - At most two gnt bits are high. A requester is never granted twice in one cycle.
- Packing:
  - One grant: `g0` goes to slot 1, `q_valid2`=0, `q_data2`=0.
  - Two grants: `g0` goes to slot 1, `g1` goes to slot 2.
  - Slot 2 is never valid without slot 1.
- `rr_ptr` (width clog2(NUM_REQ)) updates to (last granted index + 1) mod NUM_REQ.
  - It holds when nothing is granted.
  - It resets to 0.
  - It is retained across flushes.
- FSM states IDLE, FLUSH, QUIESCE:
  - IDLE to FLUSH when flush_req=1. Grants in that cycle are suppressed.
  - FLUSH lasts 1 cycle: `q_flush`=1, all gnt=0, q_valids=0. It always goes to QUIESCE.
  - QUIESCE: `qcnt` loads QUIESCE_CYCLES on entry and decrements each cycle. All gnt=0. Go to IDLE when `qcnt`==1.
  - flush_req in FLUSH or QUIESCE re-enters FLUSH next cycle, restarting the sequence.
- Non-granted requesters keep req asserted. The block stores nothing per requester.

## Timing
- gnt is combinational from req, stall_in, rr_ptr and state. It has no registered delay.
- Latency: data granted in cycle N appears on `q_valid*/q_data*` after the rising edge ending cycle N, one cycle.
- `q_valid*` are high for exactly one cycle per grant. They drop to 0 with no grant.
- `q_flush` is high for exactly one cycle, registered, in the cycle after flush_req is sampled.
- Flush arriving with grants pending in the same cycle: the flush wins; those requests are not granted.
- Reset asserted (rst=0) at any time:
  - Immediately: q_valid1/2=0, q_data1/2=0, q_flush=0, busy=0, state=IDLE, rr_ptr=0, qcnt=0.
  - gnt=0 while rst=0.
- First grant is possible in the first cycle after rst deasserts.

## Test plan
- All req=1111, stall_in=00, five cycles:
  - gnt sequence 0011, 1100, 0011, 1100, 0011.
  - Slots carry data0/data1, then data2/data3, and so on, one cycle later.
- req=0100, stall_in=00:
  - gnt=0100.
  - Next cycle q_valid1=1, q_data1=data2, q_valid2=0, q_data2=0.
  - rr_ptr becomes 3.
- req=1111, stall_in=10 then 11 then 01:
  - First cycle: single grant, gnt=0001.
  - Then gnt=0000 for both 11 and 01.
  - q_valid2 never 1.
- flush_req pulse in cycle 0 with req=1111, QUIESCE_CYCLES=2:
  - gnt=0 in cycles 0..3; q_flush=1 in cycle 1 only; busy=1 in cycles 1..3.
  - Grants resume in cycle 4 from the retained rr_ptr.
- flush_req again in the first QUIESCE cycle: FLUSH is re-entered and q_flush pulses a second time; the quiesce window restarts.
- rst driven low mid-stream with q_valid1/2=1:
  - All outputs go to 0 asynchronously, before the next edge.
  - After release, the first grant with req=1111 is 0011 (rr_ptr=0).

Source files
------------

// File: rtl/queue_issue_arbiter_if.sv
// Issue-side bundle between producer stages, the issue arbiter and the dual-slot queue.
interface queue_issue_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [1:0]                    stall_in;
  logic                          flush_req;
  logic                          q_valid1;
  logic                          q_valid2;
  logic [DATA_WIDTH-1:0]         q_data1;
  logic [DATA_WIDTH-1:0]         q_data2;
  logic                          q_flush;
  logic                          busy;

  modport master (
    output req, req_data, stall_in, flush_req,
    input  gnt, q_valid1, q_valid2, q_data1, q_data2, q_flush, busy
  );

  modport slave (
    input  req, req_data, stall_in, flush_req,
    output gnt, q_valid1, q_valid2, q_data1, q_data2, q_flush, busy
  );
endinterface

// File: rtl/queue_issue_arbiter.sv
// Round-robin two-wide issue arbiter feeding the dual-slot pipeline queue,
// with a FLUSH pulse followed by a fixed no-grant quiesce window.
module queue_issue_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_REQ        = 4,
  parameter int QUIESCE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  queue_issue_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, FLUSH, QUIESCE} state_t;

  state_t                state;
  logic [3:0]            qcnt;
  logic [PTR_W-1:0]      rr_ptr;
  logic                  q_flush_p1;
  logic                  busy_p1;
  logic                  q_valid1_p1;
  logic                  q_valid2_p1;
  logic [DATA_WIDTH-1:0] q_data1_p1;
  logic [DATA_WIDTH-1:0] q_data2_p1;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [1:0]            cap;
  logic                  g0_found;
  logic                  g1_found;
  logic [PTR_W-1:0]      g0_idx;
  logic [PTR_W-1:0]      g1_idx;
  logic                  allow;
  logic                  take0;
  logic                  take1;
  logic [NUM_REQ-1:0]    gnt_c;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stall code 01 is illegal and treated as a full queue.
  always_comb begin
    case (bus.stall_in)
      2'b00:   cap = 2'd2;
      2'b10:   cap = 2'd1;
      default: cap = 2'd0;
    endcase
  end

  always_comb begin
    int idx;
    idx      = 0;
    g0_found = 1'b0;
    g1_found = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[idx[PTR_W-1:0]]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = idx[PTR_W-1:0];
        end else if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = idx[PTR_W-1:0];
        end
      end
    end
  end

  // A flush request wins over any grant in the same cycle.
  assign allow = rst && (state == IDLE) && !bus.flush_req;
  assign take0 = allow && g0_found && (cap != 2'd0);
  assign take1 = allow && g1_found && (cap == 2'd2);

  always_comb begin
    gnt_c = '0;
    if (take0) gnt_c[g0_idx] = 1'b1;
    if (take1) gnt_c[g1_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      qcnt       <= '0;
      q_flush_p1 <= 1'b0;
      busy_p1    <= 1'b0;
    end else if (bus.flush_req) begin
      state      <= FLUSH;
      qcnt       <= '0;
      q_flush_p1 <= 1'b1;
      busy_p1    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          q_flush_p1 <= 1'b0;
          busy_p1    <= 1'b0;
        end
        FLUSH: begin
          state      <= QUIESCE;
          qcnt       <= 4'(QUIESCE_CYCLES);
          q_flush_p1 <= 1'b0;
          busy_p1    <= 1'b1;
        end
        QUIESCE: begin
          q_flush_p1 <= 1'b0;
          if (qcnt <= 4'd1) begin
            state   <= IDLE;
            qcnt    <= '0;
            busy_p1 <= 1'b0;
          end else begin
            qcnt    <= qcnt - 4'd1;
            busy_p1 <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          qcnt       <= '0;
          q_flush_p1 <= 1'b0;
          busy_p1    <= 1'b0;
        end
      endcase
    end
  end

  // Issue stage -> queue slot registers (one cycle latency)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr      <= '0;
      q_valid1_p1 <= 1'b0;
      q_valid2_p1 <= 1'b0;
      q_data1_p1  <= '0;
      q_data2_p1  <= '0;
    end else begin
      q_valid1_p1 <= take0;
      q_valid2_p1 <= take1;
      q_data1_p1  <= take0 ? data_arr[g0_idx] : '0;
      q_data2_p1  <= take1 ? data_arr[g1_idx] : '0;
      if (take1)      rr_ptr <= inc_ptr(g1_idx);
      else if (take0) rr_ptr <= inc_ptr(g0_idx);
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.q_valid1 = q_valid1_p1;
  assign bus.q_valid2 = q_valid2_p1;
  assign bus.q_data1  = q_data1_p1;
  assign bus.q_data2  = q_data2_p1;
  assign bus.q_flush  = q_flush_p1;
  assign bus.busy     = busy_p1;

endmodule

// File: tb/tb_queue_issue_arbiter.sv
// Bench for queue_issue_arbiter: directed scenarios plus random traffic against
// a list-based round-robin model with a flush blackout counter.
module tb_queue_issue_arbiter;
  localparam int DATA_WIDTH     = 16;
  localparam int NUM_REQ        = 4;
  localparam int QUIESCE_CYCLES = 2;
  localparam int PW             = $clog2(NUM_REQ);

  logic clk = 1'b0;
  logic rst;

  queue_issue_arbiter_if #(.DATA_WIDTH(DATA_WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  queue_issue_arbiter #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REQ(NUM_REQ),
    .QUIESCE_CYCLES(QUIESCE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: next round-robin start and cycles left in the flush blackout.
  int m_ptr;
  int m_block;
  logic [NUM_REQ-1:0]    obs_gnt;
  logic                  e_v1, e_v2, e_flush, e_busy;
  logic [DATA_WIDTH-1:0] e_d1, e_d2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_block = 0;
    e_v1    = 1'b0;
    e_v2    = 1'b0;
    e_d1    = '0;
    e_d2    = '0;
    e_flush = 1'b0;
    e_busy  = 1'b0;
  endtask

  task automatic check_regs();
    chk("q_valid1", 64'(bus.q_valid1), 64'(e_v1));
    chk("q_valid2", 64'(bus.q_valid2), 64'(e_v2));
    chk("q_data1",  64'(bus.q_data1),  64'(e_d1));
    chk("q_data2",  64'(bus.q_data2),  64'(e_d2));
    chk("q_flush",  64'(bus.q_flush),  64'(e_flush));
    chk("busy",     64'(bus.busy),     64'(e_busy));
  endtask

  // Starts at a falling edge, ends at the next falling edge.
  task automatic cycle(input logic [NUM_REQ-1:0] r, input logic [1:0] s, input logic f);
    logic [NUM_REQ*DATA_WIDTH-1:0] rd;
    logic [NUM_REQ-1:0]            exp_gnt;
    logic [PW-1:0]                 ix;
    int cap, n;
    int order [2];
    for (int i = 0; i < NUM_REQ; i++) rd[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom());
    bus.req       = r;
    bus.req_data  = rd;
    bus.stall_in  = s;
    bus.flush_req = f;
    cap = (s == 2'b00) ? 2 : (s == 2'b10) ? 1 : 0;
    exp_gnt  = '0;
    n        = 0;
    order[0] = 0;
    order[1] = 0;
    if (!f && m_block == 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        ix = PW'((m_ptr + k) % NUM_REQ);
        if (r[ix] && n < cap) begin
          order[n]    = int'(ix);
          exp_gnt[ix] = 1'b1;
          n++;
        end
      end
    end
    #1;
    obs_gnt = bus.gnt;
    chk("gnt", 64'(obs_gnt), 64'(exp_gnt));
    e_v1 = (n >= 1);
    e_v2 = (n == 2);
    e_d1 = (n >= 1) ? rd[order[0]*DATA_WIDTH +: DATA_WIDTH] : '0;
    e_d2 = (n == 2) ? rd[order[1]*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (n > 0) m_ptr = (order[n-1] + 1) % NUM_REQ;
    if (f) m_block = 1 + QUIESCE_CYCLES;
    else if (m_block > 0) m_block--;
    e_flush = f;
    e_busy  = (m_block > 0);
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  initial begin
    logic [NUM_REQ-1:0] rr_seq [5];
    logic [1:0]         st_tab [4];
    rr_seq = '{4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0011};
    st_tab = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Reset state, with requests already pending
    rst           = 1'b0;
    bus.req       = '1;
    bus.req_data  = '0;
    bus.stall_in  = 2'b00;
    bus.flush_req = 1'b0;
    model_reset();
    #2;
    chk("reset_gnt", 64'(bus.gnt), 64'(0));
    check_regs();
    @(negedge clk);
    rst = 1'b1;

    // Full request, full capacity: pairs alternate
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 2'b00, 1'b0);
      chk("rr_pair_gnt", 64'(obs_gnt), 64'(rr_seq[i]));
    end

    // Single requester, then pointer lands on 3
    cycle(4'b0100, 2'b00, 1'b0);
    chk("single_gnt", 64'(obs_gnt), 64'(4'b0100));
    chk("single_v1", 64'(bus.q_valid1), 64'(1));
    chk("single_v2", 64'(bus.q_valid2), 64'(0));
    cycle(4'b1111, 2'b10, 1'b0);
    chk("cap1_gnt", 64'(obs_gnt), 64'(4'b1000));
    chk("cap1_v2", 64'(bus.q_valid2), 64'(0));
    cycle(4'b1111, 2'b11, 1'b0);
    chk("cap0_gnt", 64'(obs_gnt), 64'(0));
    cycle(4'b1111, 2'b01, 1'b0);
    chk("illegal_stall_gnt", 64'(obs_gnt), 64'(0));

    // Flush then quiesce window, grants resume from retained pointer (0)
    cycle(4'b1111, 2'b00, 1'b1);
    chk("flush_cycle_gnt", 64'(obs_gnt), 64'(0));
    chk("flush_pulse", 64'(bus.q_flush), 64'(1));
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 2'b00, 1'b0);
      chk("quiesce_gnt", 64'(obs_gnt), 64'(0));
    end
    cycle(4'b1111, 2'b00, 1'b0);
    chk("resume_gnt", 64'(obs_gnt), 64'(4'b0011));

    // Flush re-entered during the first quiesce cycle
    cycle(4'b1111, 2'b00, 1'b1);
    cycle(4'b1111, 2'b00, 1'b0);
    cycle(4'b1111, 2'b00, 1'b1);
    chk("reflush_pulse", 64'(bus.q_flush), 64'(1));
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 2'b00, 1'b0);
      chk("reflush_quiet_gnt", 64'(obs_gnt), 64'(0));
    end
    cycle(4'b1111, 2'b00, 1'b0);
    chk("reflush_resume_gnt", 64'(obs_gnt), 64'(4'b1100));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(NUM_REQ'($urandom()), st_tab[$urandom_range(0, 3)], ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(4'b0000, 2'b00, 1'b0);

    // Asynchronous reset while both slots are valid
    cycle(4'b1111, 2'b00, 1'b0);
    chk("pre_reset_v1", 64'(bus.q_valid1), 64'(1));
    chk("pre_reset_v2", 64'(bus.q_valid2), 64'(1));
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_reset_gnt", 64'(bus.gnt), 64'(0));
    check_regs();
    @(negedge clk);
    rst = 1'b1;
    cycle(4'b1111, 2'b00, 1'b0);
    chk("post_reset_gnt", 64'(obs_gnt), 64'(4'b0011));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
